// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control: prioritised stall bus, registered flush/redirect, debug halt,
// stall watchdog and per-requester stall-cycle counters.
module pipe_hazard_ctrl #(
  parameter int                  STAGES    = 6,
  parameter int                  NREQ      = 4,
  parameter logic [4*NREQ-1:0]   REQ_LVL   = 16'h5432,
  parameter int                  PC_W      = 32,
  parameter int                  MAX_STALL = 64,
  parameter int                  SEL_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              flush_req,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              halt_req,
  input  logic [SEL_W-1:0]  perf_sel,
  input  logic              perf_clr,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              halted,
  output logic              stall_timeout,
  output logic [31:0]       perf_cnt
);

  localparam int              WD_W   = $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

  typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

  state_t              state;
  logic [STAGES-1:0]   req_stall;
  logic [WD_W-1:0]     wd_cnt;
  logic [31:0]         perf [NREQ];

  // A level at or beyond the bus width freezes every stage.
  function automatic logic [STAGES-1:0] lvl_mask(input logic [3:0] lvl);
    logic [STAGES-1:0] m;
    m = '0;
    for (int k = 0; k < STAGES; k++)
      if (k <= int'(lvl)) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] c);
    return (c == WD_MAX) ? c : c + 1'b1;
  endfunction

  always_comb begin
    req_stall = '0;
    for (int i = 0; i < NREQ; i++)
      if (stall_req[i]) req_stall = req_stall | lvl_mask(REQ_LVL[4*i +: 4]);
  end

  always_comb begin
    stall = '0;
    if (!rst) begin
      case (state)
        RUN:     stall = req_stall;
        HOLD:    stall = '1;
        default: stall = '0;
      endcase
    end
  end

  // Flush beats halt from every state; outputs are registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      flush  <= 1'b0;
      halted <= 1'b0;
      new_pc <= '0;
    end else if (flush_req) begin
      state  <= FLUSH;
      flush  <= 1'b1;
      halted <= 1'b0;
      new_pc <= flush_pc;
    end else if (halt_req) begin
      state  <= HOLD;
      flush  <= 1'b0;
      halted <= 1'b1;
    end else begin
      state  <= RUN;
      flush  <= 1'b0;
      halted <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (|req_stall) begin
            wd_cnt <= wd_sat_inc(wd_cnt);
            if (wd_cnt == WD_MAX - 1'b1) stall_timeout <= 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        FLUSH:   wd_cnt <= '0;
        default: wd_cnt <= wd_cnt;
      endcase
      if (flush_req) stall_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst || perf_clr)  perf[i] <= '0;
      else if (state == RUN) perf[i] <= perf[i] + 32'(stall_req[i]);
    end
  end

  always_comb begin
    perf_cnt = '0;
    for (int i = 0; i < NREQ; i++)
      if (32'(perf_sel) == i) perf_cnt = perf[i];
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_pipe_hazard_ctrl;

  localparam int STAGES = 6;
  localparam int NREQ   = 4;
  localparam int PC_W   = 32;
  localparam int MAXS   = 8;
  localparam int SEL_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   stall_req;
  logic              flush_req;
  logic [PC_W-1:0]   flush_pc;
  logic              halt_req;
  logic [SEL_W-1:0]  perf_sel;
  logic              perf_clr;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic              halted;
  logic              stall_timeout;
  logic [31:0]       perf_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  pipe_hazard_ctrl #(
    .STAGES(STAGES), .NREQ(NREQ), .REQ_LVL(16'h5432), .PC_W(PC_W),
    .MAX_STALL(MAXS), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .flush_pc(flush_pc), .halt_req(halt_req), .perf_sel(perf_sel), .perf_clr(perf_clr),
    .stall(stall), .flush(flush), .new_pc(new_pc), .halted(halted),
    .stall_timeout(stall_timeout), .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: mode 0=running, 1=flushing, 2=halted
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_to;
  int          m_wd;
  logic [31:0] m_cnt [NREQ];
  int          lvls [NREQ] = '{2, 3, 4, 5};

  function automatic logic [STAGES-1:0] m_stall();
    int acc;
    acc = 0;
    if (rst) return '0;
    if (m_mode == 1) return '0;
    if (m_mode == 2) return '1;
    for (int i = 0; i < NREQ; i++)
      if (stall_req[i])
        acc = acc | ((lvls[i] >= STAGES) ? ((1 << STAGES) - 1) : ((1 << (lvls[i] + 1)) - 1));
    return STAGES'(acc);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pc = 0; m_to = 0; m_wd = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else begin
      if (m_mode == 0) begin
        if (m_stall() != 0) begin
          if (m_wd < MAXS) begin
            m_wd = m_wd + 1;
            if (m_wd == MAXS) m_to = 1;
          end
        end else m_wd = 0;
      end else if (m_mode == 1) m_wd = 0;
      for (int i = 0; i < NREQ; i++)
        if (perf_clr) m_cnt[i] = 0;
        else if (m_mode == 0) m_cnt[i] = m_cnt[i] + {31'b0, stall_req[i]};
      if (flush_req) begin
        m_mode = 1; m_pc = flush_pc; m_to = 0;
      end else m_mode = halt_req ? 2 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(m_stall()));
      chk("flush", 32'(flush), 32'(m_mode == 1));
      chk("new_pc", new_pc, m_pc);
      chk("halted", 32'(halted), 32'(m_mode == 2));
      chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
      chk("perf_cnt", perf_cnt, (int'(perf_sel) < NREQ) ? m_cnt[perf_sel] : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sr, input logic fr, input logic [31:0] pc, input logic hr);
    stall_req = sr; flush_req = fr; flush_pc = pc; halt_req = hr;
  endtask

  initial begin
    rst = 1'b1; perf_sel = 0; perf_clr = 0;
    drive(4'b0001, 0, 0, 0);
    tick(); chk_en = 1;
    tick();
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_new_pc", new_pc, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_timeout", 32'(stall_timeout), 0);
    chk("rst_perf", perf_cnt, 0);
    rst = 1'b0;

    drive(4'b0001, 0, 0, 0); #1; chk("mask_req0", 32'(stall), 32'h07); tick();
    drive(4'b0011, 0, 0, 0); #1; chk("mask_req01", 32'(stall), 32'h0F); tick();
    drive(4'b1000, 0, 0, 0); #1; chk("mask_req3", 32'(stall), 32'h3F); tick();
    drive(4'b0000, 0, 0, 0); #1; chk("mask_none", 32'(stall), 32'h00); tick();

    drive(4'b0001, 1, 32'hBFC00380, 0); tick();
    drive(4'b0001, 0, 0, 0); #1;
    chk("flush_pulse", 32'(flush), 1);
    chk("flush_pc", new_pc, 32'hBFC00380);
    chk("flush_stall", 32'(stall), 0);
    tick();
    chk("flush_end", 32'(flush), 0);
    chk("post_flush_stall", 32'(stall), 32'h07);
    drive(0, 0, 0, 0); tick();

    drive(0, 0, 0, 1); tick(); #1;
    chk("hold_halted", 32'(halted), 1);
    chk("hold_stall", 32'(stall), 32'h3F);
    drive(0, 1, 32'h00001234, 1); tick();
    drive(0, 0, 0, 1); #1;
    chk("hold_flush", 32'(flush), 1);
    chk("hold_flush_halted", 32'(halted), 0);
    chk("hold_flush_pc", new_pc, 32'h00001234);
    tick();
    chk("rehold", 32'(halted), 1);
    tick(); tick();
    drive(0, 0, 0, 0); tick(); #1;
    chk("unhold", 32'(halted), 0);
    chk("unhold_stall", 32'(stall), 0);

    drive(4'b0010, 0, 0, 0);
    repeat (7) tick();
    chk("wd_before", 32'(stall_timeout), 0);
    tick();
    chk("wd_fire", 32'(stall_timeout), 1);
    tick(); tick();
    chk("wd_sticky", 32'(stall_timeout), 1);
    drive(4'b0010, 1, 32'hCAFE0000, 0); tick();
    drive(0, 0, 0, 0); #1;
    chk("wd_cleared", 32'(stall_timeout), 0);
    tick();

    perf_clr = 1; tick(); perf_clr = 0; perf_sel = 2;
    drive(4'b0100, 0, 0, 0);
    repeat (9) tick();
    drive(4'b0100, 0, 0, 1); tick();
    repeat (3) tick();
    drive(4'b0100, 0, 0, 0); #1;
    chk("perf_hold", perf_cnt, 10);
    tick();
    chk("perf_after_hold", perf_cnt, 10);
    perf_clr = 1; tick(); perf_clr = 0;
    chk("perf_clr", perf_cnt, 0);
    tick();
    chk("perf_resume", perf_cnt, 1);
    drive(0, 0, 0, 0); tick();

    drive(0, 1, 32'hAAAA0000, 0); tick();
    drive(0, 1, 32'hBBBB0004, 0); #1;
    chk("b2b_a_flush", 32'(flush), 1);
    chk("b2b_a_pc", new_pc, 32'hAAAA0000);
    tick();
    drive(0, 0, 0, 0); #1;
    chk("b2b_b_flush", 32'(flush), 1);
    chk("b2b_b_pc", new_pc, 32'hBBBB0004);
    tick();
    chk("b2b_end", 32'(flush), 0);
    chk("b2b_hold_pc", new_pc, 32'hBBBB0004);
    drive(0, 1, 32'h0C0C0C0C, 1); tick();
    rst = 1'b1;
    drive(4'b0001, 1, 32'hDDDD0000, 1); #1;
    chk("rst_in_flush_stall", 32'(stall), 0);
    tick();
    chk("rst_flush_clr", 32'(flush), 0);
    chk("rst_pc_clr", new_pc, 0);
    chk("rst_halt_clr", 32'(halted), 0);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
